// File: rtl/bias_pkg.sv
// Shared types and default geometry for the bias RAM loader.
package bias_pkg;
   localparam int DEPTH_DEF = 64;
   localparam int AW_DEF    = 6;
   localparam int DW_DEF    = 8;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
endpackage

// File: rtl/bias_ram_loader_if.sv
// Upstream byte stream into the bias loader (valid/ready).
interface bias_if
   import bias_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/bias_ram_64x8.sv
// Bias storage: synchronous write port, combinational read port, no reset.
module bias_ram_64x8
   import bias_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/bias_ram_loader.sv
// Loads DEPTH bias words from a byte stream, verifies a trailing modulo-2^DW
// checksum, and serves the image to the CNN engine through a combinational read port.
module bias_ram_loader
   import bias_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   bias_if.slave         s,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          loaded,
   output logic          err
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state, nstate;
   logic [AW-1:0] addr;
   logic [DW-1:0] sum;
   logic          hs;
   logic          we;

   assign s.s_ready = (state == LOAD) || (state == CHECK);
   assign busy      = s.s_ready;
   assign hs        = s.s_valid && s.s_ready;
   // start wins over a coincident handshake: that byte is never written
   assign we        = (state == LOAD) && hs && !start;

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    nstate = IDLE;
         LOAD:    if (hs && addr == LAST) nstate = CHECK;
         CHECK:   if (hs) nstate = DONE;
         DONE:    nstate = DONE;
         default: nstate = IDLE;
      endcase
      if (start) nstate = LOAD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         addr   <= '0;
         sum    <= '0;
         loaded <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= nstate;
         if (start) begin
            addr   <= '0;
            sum    <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
         end else if (hs && state == LOAD) begin
            addr <= (addr == LAST) ? '0 : addr + 1'b1;
            sum  <= sum + s.s_data;
         end else if (hs && state == CHECK) begin
            loaded <= (s.s_data == sum);
            err    <= (s.s_data != sum);
         end
      end
   end

   bias_ram_64x8 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (addr),
      .wdata (s.s_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );
endmodule

// File: tb/tb_bias_ram_loader.sv
// Directed bench for bias_ram_loader: vector table plus backpressure and reset sequences.
module tb_bias_ram_loader;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy, loaded, err;

   bias_if #(.DW(8)) sif ();

   bias_ram_loader #(.DEPTH(64), .AW(6), .DW(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .s       (sif.slave),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .loaded  (loaded),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       sv;
      logic [7:0] sd;
      logic [5:0] ra;
      logic       eb;
      logic       el;
      logic       ee;
      logic       crd;
      logic [7:0] erd;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nbad = 0;
   int   hs_cnt = 0;

   always @(posedge clk)
      if (rst_n && sif.s_valid && sif.s_ready && !start) hs_cnt <= hs_cnt + 1;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic sv, input logic [7:0] sd, input logic [5:0] ra);
      @(negedge clk);
      start       = st;
      sif.s_valid = sv;
      sif.s_data  = sd;
      rd_addr     = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic st, input logic sv, input logic [7:0] sd, input logic [5:0] ra,
                      input logic eb, input logic el, input logic ee, input logic crd, input logic [7:0] erd);
      vec_t v;
      v.st = st; v.sv = sv; v.sd = sd; v.ra = ra;
      v.eb = eb; v.el = el; v.ee = ee; v.crd = crd; v.erd = erd;
      tbl.push_back(v);
   endtask

   // bytes 0x00..0x3F, each read back the cycle after its handshake, then checksum
   task automatic add_load(input logic [7:0] ck, input logic ok, input logic with_start);
      if (with_start) add(1, 0, 8'h00, 6'd0, 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 64; i++) add(0, 1, 8'(i), 6'(i), 1, 0, 0, 1, 8'(i));
      add(0, 1, ck, 6'd0, 0, ok, !ok, 1, 8'h00);
   endtask

   initial begin
      int base, sent, cycles;
      logic v;

      rst_n = 1'b0; start = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0; rd_addr = '0;
      #12;
      chk("rst_busy",   0, busy, 1'b0);
      chk("rst_ready",  0, sif.s_ready, 1'b0);
      chk("rst_loaded", 0, loaded, 1'b0);
      chk("rst_err",    0, err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      add_load(8'hE0, 1, 1);
      add(0, 1, 8'h55, 6'd0,  0, 1, 0, 1, 8'h00);
      add(0, 0, 8'h00, 6'd5,  0, 1, 0, 1, 8'h05);
      add(0, 0, 8'h00, 6'd63, 0, 1, 0, 1, 8'h3F);
      add_load(8'hE1, 0, 1);
      add(0, 0, 8'h00, 6'd7,  0, 0, 1, 1, 8'h07);
      add_load(8'hE0, 1, 1);
      add(1, 0, 8'h00, 6'd0, 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) add(0, 1, 8'hAA, 6'(i), 1, 0, 0, 1, 8'hAA);
      add(1, 1, 8'h77, 6'd10, 1, 0, 0, 1, 8'h0A);
      add_load(8'hE0, 1, 0);
      add(0, 0, 8'h00, 6'd3, 0, 1, 0, 1, 8'h03);

      for (int k = 0; k < tbl.size(); k++) begin
         cyc(tbl[k].st, tbl[k].sv, tbl[k].sd, tbl[k].ra);
         chk("busy",    k, busy, tbl[k].eb);
         chk("s_ready", k, sif.s_ready, tbl[k].eb);
         chk("loaded",  k, loaded, tbl[k].el);
         chk("err",     k, err, tbl[k].ee);
         if (tbl[k].crd) chk("rd_data", k, rd_data, tbl[k].erd);
      end

      // backpressure: 0xFF image with random valid gaps, garbage data while invalid
      cyc(1, 0, 8'h00, 6'd0);
      base = hs_cnt; sent = 0; cycles = 0;
      while (sent < 65 && cycles < 2000) begin
         v = ($urandom_range(0, 2) != 0);
         cyc(0, v, v ? ((sent < 64) ? 8'hFF : 8'hC0) : 8'($urandom), 6'd0);
         if (v) sent++;
         cycles++;
      end
      chk("bp_sent",   0, sent, 65);
      cyc(0, 0, 8'h00, 6'd9);
      chk("bp_hs",     0, hs_cnt - base, 65);
      chk("bp_loaded", 0, loaded, 1'b1);
      chk("bp_err",    0, err, 1'b0);
      chk("bp_busy",   0, busy, 1'b0);
      chk("bp_rd",     0, rd_data, 8'hFF);

      // reset mid-load after 20 bytes
      cyc(1, 0, 8'h00, 6'd0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 8'(i), 6'd0);
      @(negedge clk);
      sif.s_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy",   0, busy, 1'b0);
      chk("mr_ready",  0, sif.s_ready, 1'b0);
      chk("mr_loaded", 0, loaded, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      base = hs_cnt;
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'h11, 6'd0);
      chk("mr_hs",     0, hs_cnt - base, 0);
      chk("mr_busy2",  0, busy, 1'b0);
      chk("mr_loaded2",0, loaded, 1'b0);
      chk("mr_err",    0, err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
